// File: rtl/fetch_seq_pkg.sv
// rtl/fetch_seq_pkg.sv - shared state encoding and opcode constants for the fetch sequencer
package fetch_pkg;

  typedef enum logic [1:0] {
    S_OP    = 2'd0,
    S_ARG   = 2'd1,
    S_ISSUE = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam int         TWO_BYTE_BIT = 7;
  localparam logic [3:0] JMP_NIB      = 4'hF;
  localparam logic [7:0] HALT_OP      = 8'h7F;

  // Jump opcodes carry their condition mask in the low nibble.
  function automatic logic is_jump(input logic [7:0] op);
    return op[7:4] == JMP_NIB;
  endfunction

  function automatic logic is_halt(input logic [7:0] op);
    return op == HALT_OP;
  endfunction

endpackage

// File: rtl/fetch_seq_cond_eval.sv
// rtl/fetch_seq_cond_eval.sv - jump condition: mask 0 is unconditional, else any masked flag set
module cond_eval (
  input  logic [3:0] mask,
  input  logic [3:0] flags,
  output logic       take
);

  assign take = (mask == 4'h0) || ((mask & flags) != 4'h0);

endmodule

// File: rtl/fetch_seq.sv
// rtl/fetch_seq.sv - instruction fetch sequencer driving the PC incr/load pair each cycle
// Optional HALT opcode support is enabled with FETCH_SEQ_HALT_EN.
module fetch_seq
  import fetch_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] pc_addr,
  input  logic [DW-1:0] rom_data,
  input  logic [3:0]    flags,
  input  logic          ir_ready,
  output logic          pc_incr,
  output logic [AW-1:0] pc_data,
  output logic          ir_valid,
  output logic [DW-1:0] ir_op,
  output logic [DW-1:0] ir_arg,
  output logic          halted
);

  state_t state;
  state_t state_nxt;
  logic   cond_take;
  logic   jump_taken;

  cond_eval u_cond_eval (
    .mask  (ir_op[3:0]),
    .flags (flags),
    .take  (cond_take)
  );

  assign jump_taken = is_jump(ir_op[7:0]) && cond_take;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_OP;
      ir_op  <= '0;
      ir_arg <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_OP: begin
          ir_op  <= rom_data;
          ir_arg <= '0;
        end
        S_ARG:   ir_arg <= rom_data;
        default: ;
      endcase
    end
  end

  // The PC moves every clock, so "hold" is expressed as loading its own value.
  always_comb begin
    state_nxt = state;
    pc_incr   = 1'b1;
    pc_data   = pc_addr;
    ir_valid  = 1'b0;
    halted    = 1'b0;
    case (state)
      S_OP: begin
        state_nxt = rom_data[TWO_BYTE_BIT] ? S_ARG : S_ISSUE;
      end
      S_ARG: begin
        state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        ir_valid = 1'b1;
        pc_incr  = 1'b0;
        if (ir_ready) begin
          if (jump_taken) begin
            pc_data = AW'(ir_arg);
          end
          state_nxt = S_OP;
`ifdef FETCH_SEQ_HALT_EN
          if (is_halt(ir_op[7:0])) begin
            state_nxt = S_HALT;
          end
`endif
        end
      end
`ifdef FETCH_SEQ_HALT_EN
      S_HALT: begin
        halted  = 1'b1;
        pc_incr = 1'b0;
      end
`endif
      default: begin
        state_nxt = S_OP;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_seq.sv
// tb/tb_fetch_seq.sv - directed table-driven bench for fetch_seq with a PC and ROM model
module tb_fetch_seq;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] pc_addr;
  logic [7:0] rom_data;
  logic [3:0] flags = 4'h0;
  logic       ir_ready = 1'b0;
  logic       pc_incr;
  logic [7:0] pc_data;
  logic       ir_valid;
  logic [7:0] ir_op;
  logic [7:0] ir_arg;
  logic       halted;

  logic [7:0] rom [256];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  assign rom_data = rom[pc_addr];

  always_ff @(posedge clk) begin
    if (reset) pc_addr <= 8'h00;
    else       pc_addr <= pc_incr ? pc_addr + 8'd1 : pc_data;
  end

  fetch_seq #(.AW(8), .DW(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .pc_addr  (pc_addr),
    .rom_data (rom_data),
    .flags    (flags),
    .ir_ready (ir_ready),
    .pc_incr  (pc_incr),
    .pc_data  (pc_data),
    .ir_valid (ir_valid),
    .ir_op    (ir_op),
    .ir_arg   (ir_arg),
    .halted   (halted)
  );

  typedef struct {
    string      name;
    logic [7:0] b0;
    logic [7:0] b1;
    logic [3:0] flg;
    logic [7:0] op;
    logic [7:0] arg;
    int         cyc;
    logic [7:0] pcd;
    logic [7:0] nxt;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic clear_rom();
    for (int a = 0; a < 256; a++) rom[a] = 8'h00;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!ir_valid && cyc < 8) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  function automatic vec_t mk(string nm, logic [7:0] b0, logic [7:0] b1, logic [3:0] flg,
                              logic [7:0] op, logic [7:0] arg, int cyc,
                              logic [7:0] pcd, logic [7:0] nxt);
    vec_t v;
    v.name = nm; v.b0 = b0; v.b1 = b1; v.flg = flg; v.op = op; v.arg = arg;
    v.cyc = cyc; v.pcd = pcd; v.nxt = nxt;
    return v;
  endfunction

  initial begin
    int cyc;
    // flags order {N,C,Z,V}: V=bit0, Z=bit1, C=bit2, N=bit3
    vecs[0] = mk("one_byte",    8'h12, 8'h99, 4'b0000, 8'h12, 8'h00, 1, 8'h01, 8'h01);
    vecs[1] = mk("two_byte",    8'h85, 8'h3C, 4'b0000, 8'h85, 8'h3C, 2, 8'h02, 8'h02);
    vecs[2] = mk("jmp_uncond",  8'hF0, 8'h40, 4'b0000, 8'hF0, 8'h40, 2, 8'h40, 8'h40);
    vecs[3] = mk("jmp_v_clr",   8'hF1, 8'h40, 4'b0000, 8'hF1, 8'h40, 2, 8'h02, 8'h02);
    vecs[4] = mk("jmp_v_set",   8'hF1, 8'h40, 4'b0001, 8'hF1, 8'h40, 2, 8'h40, 8'h40);
    vecs[5] = mk("jmp_z_set",   8'hF2, 8'h40, 4'b0010, 8'hF2, 8'h40, 2, 8'h40, 8'h40);
    vecs[6] = mk("jmp_c_clr",   8'hF4, 8'h55, 4'b1011, 8'hF4, 8'h55, 2, 8'h02, 8'h02);
    vecs[7] = mk("jmp_self",    8'hF0, 8'h00, 4'b0000, 8'hF0, 8'h00, 2, 8'h00, 8'h00);
    vecs[8] = mk("op_zero",     8'h00, 8'hFF, 4'b1111, 8'h00, 8'h00, 1, 8'h01, 8'h01);
    vecs[9] = mk("two_not_jmp", 8'hE3, 8'h77, 4'b1111, 8'hE3, 8'h77, 2, 8'h02, 8'h02);

    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      clear_rom();
      rom[0] = vecs[i].b0;
      rom[1] = vecs[i].b1;
      flags = vecs[i].flg;
      ir_ready = 1'b1;
      do_reset();
      if (i == 0) begin
        chk("rst_valid", ir_valid, 0);
        chk("rst_incr", pc_incr, 1);
        chk("rst_pcdata", pc_data, pc_addr == 8'h00 ? 8'h00 : 8'hEE);
        chk("rst_halted", halted, 0);
        chk("rst_op", ir_op, 0);
        chk("rst_arg", ir_arg, 0);
      end
      wait_valid(cyc);
      chk({vecs[i].name, "_cyc"}, cyc, vecs[i].cyc);
      chk({vecs[i].name, "_op"}, ir_op, vecs[i].op);
      chk({vecs[i].name, "_arg"}, ir_arg, vecs[i].arg);
      chk({vecs[i].name, "_pc"}, pc_addr, 8'(vecs[i].cyc));
      chk({vecs[i].name, "_incr"}, pc_incr, 0);
      chk({vecs[i].name, "_pcdata"}, pc_data, vecs[i].pcd);
      @(negedge clk);
      chk({vecs[i].name, "_next_pc"}, pc_addr, vecs[i].nxt);
      chk({vecs[i].name, "_valid_drop"}, ir_valid, 0);
    end

    // Stall: flags changing during the stall must not matter, only handshake-cycle flags count
    clear_rom();
    rom[0] = 8'hF2; rom[1] = 8'h40;
    flags = 4'b0000; ir_ready = 1'b0;
    do_reset();
    wait_valid(cyc);
    chk("stall_cyc", cyc, 2);
    flags = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_pc", pc_addr, 8'h02);
      chk("stall_valid", ir_valid, 1);
      chk("stall_op", ir_op, 8'hF2);
      chk("stall_arg", ir_arg, 8'h40);
    end
    flags = 4'b0000; ir_ready = 1'b1;
    chk("stall_hs_pcdata", pc_data, 8'h02);
    @(negedge clk);
    chk("stall_hs_next", pc_addr, 8'h02);

    // Reset asserted while stalled in issue
    clear_rom();
    rom[0] = 8'h85; rom[1] = 8'h3C;
    ir_ready = 1'b0;
    do_reset();
    wait_valid(cyc);
    for (int k = 0; k < 3; k++) @(negedge clk);
    chk("rstall_pc_before", pc_addr, 8'h02);
    do_reset();
    chk("rstall_valid", ir_valid, 0);
    chk("rstall_pc", pc_addr, 8'h00);
    chk("rstall_incr", pc_incr, 1);
    chk("rstall_op", ir_op, 8'h00);
    wait_valid(cyc);
    chk("rstall_refetch_arg", ir_arg, 8'h3C);

    // Wrap: jump to 0xFF, two-byte opcode there takes operand from 0x00
    clear_rom();
    rom[0] = 8'hF0; rom[1] = 8'hFF; rom[255] = 8'h85;
    ir_ready = 1'b1;
    do_reset();
    wait_valid(cyc);
    @(negedge clk);
    chk("wrap_jmp_pc", pc_addr, 8'hFF);
    wait_valid(cyc);
    chk("wrap_cyc", cyc, 2);
    chk("wrap_op", ir_op, 8'h85);
    chk("wrap_arg", ir_arg, 8'hF0);
    chk("wrap_pc", pc_addr, 8'h01);

    // Opcode 0x7F: HALT only when the feature is built in
    clear_rom();
    rom[0] = 8'h7F; rom[1] = 8'h12;
    ir_ready = 1'b1;
    do_reset();
    wait_valid(cyc);
    chk("h7f_op", ir_op, 8'h7F);
    @(negedge clk);
`ifdef FETCH_SEQ_HALT_EN
    for (int k = 0; k < 4; k++) begin
      chk("halt_flag", halted, 1);
      chk("halt_valid", ir_valid, 0);
      chk("halt_pc", pc_addr, 8'h01);
      @(negedge clk);
    end
    do_reset();
    chk("halt_exit", halted, 0);
`else
    chk("h7f_halted", halted, 0);
    chk("h7f_pc", pc_addr, 8'h01);
    wait_valid(cyc);
    chk("h7f_next_op", ir_op, 8'h12);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
